// File: rtl/cache_pkg.sv
// Shared types for the cache result FIFO: byte type, checker states and the
// byte-restore helper that undoes the cache stage's output inversion.
package cache_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    SEQ_SYNC  = 1'b0,
    SEQ_TRACK = 1'b1
  } seq_state_e;

  function automatic byte_t restore_byte(input byte_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 register array with one synchronous write port and one
// asynchronous read port; holds FIFO payload only, so it carries no reset.
module sync_fifo_mem
  import cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_result_fifo.sv
// Restores the cache stage's inverted byte stream, buffers it in a FWFT FIFO
// with valid/ready output, and counts breaks in the incrementing sequence.
module cache_result_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     in_sync,
  output logic [CNT_W-1:0]         mismatch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Output handshake: a byte leaves the FIFO on any edge where out_valid and
  // out_ready are both high; out_ready while out_valid is low has no effect.
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  seq_state_e       state_q, state_d;
  byte_t            expected_q, expected_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  byte_t restored;
  byte_t head_data;
  logic  full, empty, push, pop;

  assign restored = restore_byte(in_data);
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign pop      = out_ready && !empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push     = in_valid && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (in_valid && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Checker watches every offered byte, including ones dropped while full.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    mcnt_d     = mcnt_q;
    if (in_valid) begin
      expected_d = restored + 8'd1;
      if (state_q == SEQ_SYNC) begin
        state_d = SEQ_TRACK;
      end else if ((restored != expected_q) && (mcnt_q != '1)) begin
        mcnt_d = mcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= SEQ_SYNC;
      expected_q <= '0;
      mcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      expected_q <= expected_d;
      mcnt_q     <= mcnt_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (restored),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  assign out_valid      = !empty;
  assign out_data       = empty ? 8'h00 : head_data;
  assign level          = level_q;
  assign overflow       = overflow_q;
  assign in_sync        = (state_q == SEQ_TRACK);
  assign mismatch_count = mcnt_q;

endmodule
